// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM byte-stream loader: FSM state encoding,
// word geometry and target selection codes.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int   BYTES_PER_WORD = 4;
  localparam logic TARGET_INSTR   = 1'b0;
  localparam logic TARGET_DATA    = 1'b1;

endpackage

// File: rtl/ram_loader_if.sv
// Session control, byte stream and RAM write-port bundle of the loader.
// master = host/core side, slave = loader side.
interface ram_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  target;
  logic [ADDR_WIDTH:0]   word_count;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  fetch_ram_load;
  logic                  mem_ram_load;
  logic                  ram_write_enable;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [31:0]           ram_write_data;
  logic                  busy;
  logic                  done;
  logic                  checksum_error;

  modport master (
    output start, target, word_count, byte_valid, byte_data,
    input  byte_ready, fetch_ram_load, mem_ram_load, ram_write_enable,
           ram_address, ram_write_data, busy, done, checksum_error
  );

  modport slave (
    input  start, target, word_count, byte_valid, byte_data,
    output byte_ready, fetch_ram_load, mem_ram_load, ram_write_enable,
           ram_address, ram_write_data, busy, done, checksum_error
  );
endinterface

// File: rtl/ram_loader_byte_word_packer.sv
// Big-endian byte-to-word packer. The first byte of a word lands in
// bits [31:24]. word/word_ready are combinational so the FSM can register
// the completed word on the same edge that accepts the final byte.
module byte_word_packer
  import ram_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] pack_q, pack_d;

  assign word       = {pack_q, byte_in};
  assign word_ready = byte_en & (idx_q == LAST_IDX);

  // Advance the byte index and shift in earlier bytes of the word.
  always_comb begin
    idx_d  = idx_q;
    pack_d = pack_q;
    if (clear) begin
      idx_d = 2'd0;
    end else if (byte_en) begin
      idx_d  = idx_q + 2'd1;
      pack_d = {pack_q[15:0], byte_in};
    end
  end

  // Index is control and is reset; the pack register only holds data.
  always_ff @(posedge clock) begin
    if (reset) idx_q <= 2'd0;
    else       idx_q <= idx_d;
    pack_q <= pack_d;
  end

endmodule

// File: rtl/ram_loader.sv
// Byte-stream RAM loader: packs bytes big-endian into 32-bit words and
// writes them to consecutive word addresses from 0, owning the selected
// RAM's write port for the whole session.
// Optional feature macro: RAM_LOADER_CHECKSUM_EN adds a trailing 32-bit
// checksum word compared against the mod-2^32 sum of the written words.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  ram_loader_if.slave  bus
);

`ifdef RAM_LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER_DATA = ST_CHECK;
`else
  localparam state_e ST_AFTER_DATA = ST_DONE;
`endif
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic                  target_q, target_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fetch_q, fetch_d;
  logic                  mem_q, mem_d;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [31:0]           sum_q, sum_d;
  logic                  chk_err_q, chk_err_d;
`endif

  logic        accept;
  logic        word_ready;
  logic [31:0] word;

  assign accept = bus.byte_valid & byte_ready_q;

  byte_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (state_q == ST_IDLE),
    .byte_en    (accept),
    .byte_in    (bus.byte_data),
    .word       (word),
    .word_ready (word_ready)
  );

  // Next-state and next-output decode; outputs follow the next state so
  // they are registered and aligned with the state they describe.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef RAM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    chk_err_d = chk_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          target_d = bus.target;
          cnt_d    = bus.word_count;
          addr_d   = '0;
`ifdef RAM_LOADER_CHECKSUM_EN
          sum_d     = '0;
          chk_err_d = 1'b0;
`endif
          state_d  = (bus.word_count == '0) ? ST_AFTER_DATA : ST_RECV;
        end
      end
      ST_RECV: begin
        if (word_ready) begin
          wdata_d = word;
          state_d = ST_WRITE;
`ifdef RAM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + word;
`endif
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q - CNT_ONE;
        // The address stays on the last word so a full-depth load never wraps.
        if (cnt_q == CNT_ONE) begin
          state_d = ST_AFTER_DATA;
        end else begin
          state_d = ST_RECV;
          addr_d  = addr_q + ADDR_ONE;
        end
      end
      ST_CHECK: begin
`ifdef RAM_LOADER_CHECKSUM_EN
        if (word_ready) begin
          chk_err_d = (word != sum_q);
          state_d   = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d       = (state_d != ST_IDLE);
    byte_ready_d = (state_d == ST_RECV) || (state_d == ST_CHECK);
    we_d         = (state_d == ST_WRITE);
    done_d       = (state_d == ST_DONE);
    fetch_d      = busy_d && (target_d == TARGET_INSTR);
    mem_d        = busy_d && (target_d == TARGET_DATA);
  end

  // FSM state, session registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      target_q     <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fetch_q      <= 1'b0;
      mem_q        <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      chk_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fetch_q      <= fetch_d;
      mem_q        <= mem_d;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
      chk_err_q    <= chk_err_d;
`endif
    end
  end

  assign bus.byte_ready       = byte_ready_q;
  assign bus.ram_write_enable = we_q;
  assign bus.ram_address      = addr_q;
  assign bus.ram_write_data   = wdata_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.fetch_ram_load   = fetch_q;
  assign bus.mem_ram_load     = mem_q;
`ifdef RAM_LOADER_CHECKSUM_EN
  assign bus.checksum_error   = chk_err_q;
`else
  assign bus.checksum_error   = 1'b0;
`endif

endmodule
